transfer_engine: RTL and testbench
==================================

// Module: transfer_engine
// PURPOSE
//  Parametrised successor to the two-player transaction datapath. Holds NUM_PLAYERS
//  balances and public keys in internal registers. Runs a fixed FSM to process one
//  transfer request: range check, amount check, key check, commit. Reports the result
//  with a one-cycle done pulse and an error code. Sits between the top-level control
//  FSM and the display/memory logic.
// PARAMETERS
//  NUM_PLAYERS  4      number of accounts (>=2)
//  AMT_W        11     balance/amount width, unsigned
//  KEY_W        8      key width
//  KEY_SALT     8'hA5  XOR salt for key transform (KEY_W bits)
//  ID_W         $clog2(NUM_PLAYERS)  player-index width (derived, not overridable)
// PORTS
//  clock        in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  start        in   1      request strobe; sampled only in IDLE
//  src_id       in   ID_W   payer index
//  dst_id       in   ID_W   payee index
//  input_amount in   AMT_W  transfer amount
//  input_key    in   KEY_W  payer's private key
//  cfg_we       in   1      write balance+key of cfg_id; accepted only when !busy
//  cfg_id       in   ID_W   account being configured
//  cfg_balance  in   AMT_W  balance to load
//  cfg_pubkey   in   KEY_W  public key to load
//  rd_id        in   ID_W   balance read index
//  rd_balance   out  AMT_W  balance[rd_id], combinational; 0 if rd_id>=NUM_PLAYERS
//  busy         out  1      high from the cycle after start is accepted until done
//  done         out  1      one-cycle pulse at the end of every accepted request
//  err_code     out  3      valid with done, held until the next accept
//  tx_count     out  16     successful-commit counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all balances 0, all keys 0, FSM=IDLE, busy=0, done=0, err_code=0, tx_count=0.
//  Accept: in IDLE with start=1, latch src_id/dst_id/input_amount/input_key. Go to CHK_ID.
//   start while busy is ignored. Do not queue it.
//  FSM states and transitions, one cycle each:
//   IDLE   -> CHK_ID on start
//   CHK_ID -> FAIL(err=3) if src>=NUM_PLAYERS, dst>=NUM_PLAYERS, or src==dst; else CHK_AMT
//   CHK_AMT-> FAIL(err=1) if amount>bal[src];
//             FAIL(err=4) if bal[dst]+amount overflows AMT_W (carry out); else CHK_KEY
//   CHK_KEY-> FAIL(err=2) unless ({key[KEY_W-4:0],key[KEY_W-1:KEY_W-3]} ^ KEY_SALT) == pubkey[src]
//             (rotate-left-by-3 of the latched key); else COMMIT
//   COMMIT -> bal[src]-=amount, bal[dst]+=amount in the same edge; DONE
//   DONE   -> done=1, err_code=0; IDLE
//   FAIL   -> done=1, err_code latched; IDLE; balances untouched
//  Latency: start accepted at edge N. Success: done high after edge N+5.
//   Failures: done high after edge N+2, N+3, or N+4 for CHK_ID, CHK_AMT, or CHK_KEY failures.
//  Back-to-back: start may be asserted in the done cycle. The FSM is in IDLE then, so the
//   request is accepted.
//  Amount 0 is legal: it passes the checks and commits with no balance change.
//  err_code: 0 ok, 1 insufficient funds, 2 bad key, 3 bad id, 4 payee overflow,
//   5-7 reserved (never driven).
//  cfg_we while busy is ignored. cfg_we with cfg_id>=NUM_PLAYERS is ignored.
//  cfg_we and start in the same IDLE cycle: the cfg write lands first, and CHK_* sees the
//   new value.
//  rd_balance reflects committed state only. Updates are visible the cycle after COMMIT.
//  Reset asserted mid-transaction: abort immediately to the reset state. No done pulse.
//   Balances are cleared.
// CONFIGURATION
//  TX_COUNT_EN defined: tx_count increments by 1 on each COMMIT. It wraps 16'hFFFF->0.
//   It is cleared by reset.
//  TX_COUNT_EN undefined: tx_count is tied to 16'h0000 and no counter register is built.
// TESTING
//  cfg p0=100 key K0, p1=50; start src=0 dst=1 amt=30 with valid key.
//   -> done at N+5, err=0, bal0=70, bal1=80.
//  src=0 amt=101 (bal0=100) -> done at N+3, err=1, balances unchanged.
//  Wrong key (input_key^1) -> done at N+4, err=2. src=dst=2 -> done at N+2, err=3.
//  bal1=2040 (AMT_W=11), send 10 to p1 -> err=4. amt=0 -> err=0, no change.
//  start asserted during busy -> ignored. Start in the done cycle -> accepted.
//   Reset at CHK_KEY -> no done, all regs 0.
//  TX_COUNT_EN: preload the counter to 16'hFFFF via 65535 commits or force -> one commit
//   wraps it to 0. Without the macro, tx_count stays 0.

Source files
------------

// File: rtl/transfer_engine.sv
// Purpose : account-transfer datapath holding NUM_PLAYERS balances and public keys;
//           validates one transfer request (ids, funds, payee overflow, key) and commits it.
// Latency : start accepted at edge N; done pulses after edge N+5 on success, and after
//           edge N+2 / N+3 / N+4 for id / amount / key failures.
// Backpressure: none queued. start and cfg_we are dropped while busy; the caller
//           retries after the done pulse (start in the done cycle is accepted).
//
// Ports:
//   i_clock, i_reset        rising-edge clock, synchronous active-high reset
//   i_start                 request strobe, sampled only in IDLE
//   i_src_id, i_dst_id      payer / payee index
//   i_input_amount          transfer amount (unsigned, AMT_W bits)
//   i_input_key             payer's private key
//   i_cfg_we/_id/_balance/_pubkey  account load port, honoured only when not busy
//   i_rd_id / o_rd_balance  combinational committed-balance read (0 when out of range)
//   o_busy                  request in flight
//   o_done, o_err_code      one-cycle completion pulse and result code
//                           (0 ok, 1 funds, 2 key, 3 id, 4 payee overflow)
//   o_tx_count              successful-commit counter
//
// Build option: define TX_COUNT_EN to build the 16-bit wrapping commit counter;
// without it o_tx_count is tied to zero and no counter register exists.

module transfer_engine #(
    parameter int               NUM_PLAYERS = 4,
    parameter int               AMT_W       = 11,
    parameter int               KEY_W       = 8,
    parameter logic [KEY_W-1:0] KEY_SALT    = 8'hA5,
    localparam int              ID_W        = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [ID_W-1:0]  i_src_id,
    input  logic [ID_W-1:0]  i_dst_id,
    input  logic [AMT_W-1:0] i_input_amount,
    input  logic [KEY_W-1:0] i_input_key,
    input  logic             i_cfg_we,
    input  logic [ID_W-1:0]  i_cfg_id,
    input  logic [AMT_W-1:0] i_cfg_balance,
    input  logic [KEY_W-1:0] i_cfg_pubkey,
    input  logic [ID_W-1:0]  i_rd_id,
    output logic [AMT_W-1:0] o_rd_balance,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_err_code,
    output logic [15:0]      o_tx_count
);

    // Storage is sized to the full index space so any ID_W-bit index is a legal
    // array reference; entries at or above NUM_PLAYERS are never written.
    localparam int              DEPTH = 1 << ID_W;
    localparam logic [ID_W:0]   NP_W  = NUM_PLAYERS[ID_W:0];

    localparam logic [2:0] ERR_OK    = 3'd0;
    localparam logic [2:0] ERR_FUNDS = 3'd1;
    localparam logic [2:0] ERR_KEY   = 3'd2;
    localparam logic [2:0] ERR_ID    = 3'd3;
    localparam logic [2:0] ERR_OVF   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHK_ID  = 3'd1,
        S_CHK_AMT = 3'd2,
        S_CHK_KEY = 3'd3,
        S_COMMIT  = 3'd4,
        S_DONE    = 3'd5,
        S_FAIL    = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Account storage
    logic [AMT_W-1:0] r_bal [0:DEPTH-1];
    logic [KEY_W-1:0] r_pub [0:DEPTH-1];

    // Latched request
    logic [ID_W-1:0]  r_src;
    logic [ID_W-1:0]  r_dst;
    logic [AMT_W-1:0] r_amt;
    logic [KEY_W-1:0] r_key;

    // Result registers
    logic [2:0]       r_fail_code;
    logic             r_done;
    logic [2:0]       r_err;

    // Check results, evaluated against the latched request every cycle
    logic [AMT_W-1:0] w_src_bal;
    logic [AMT_W-1:0] w_dst_bal;
    logic [AMT_W:0]   w_sum;
    logic [KEY_W-1:0] w_key_rot;
    logic             w_id_bad;
    logic             w_funds_bad;
    logic             w_ovf_bad;
    logic             w_key_bad;

    // FSM outputs
    logic             w_busy;
    logic             w_accept;
    logic             w_commit;
    logic             w_finish;
    logic             w_fail_set;
    logic [2:0]       w_fail_code;
    logic             w_cfg_ok;

    assign w_src_bal   = r_bal[r_src];
    assign w_dst_bal   = r_bal[r_dst];
    // One extra bit so the payee carry-out is visible as the overflow flag.
    assign w_sum       = {1'b0, w_dst_bal} + {1'b0, r_amt};
    // Public key is the private key rotated left by 3, then salted.
    assign w_key_rot   = {r_key[KEY_W-4:0], r_key[KEY_W-1:KEY_W-3]};

    assign w_id_bad    = ({1'b0, r_src} >= NP_W) || ({1'b0, r_dst} >= NP_W) || (r_src == r_dst);
    assign w_funds_bad = (r_amt > w_src_bal);
    assign w_ovf_bad   = w_sum[AMT_W];
    assign w_key_bad   = ((w_key_rot ^ KEY_SALT) != r_pub[r_src]);

    assign w_cfg_ok    = i_cfg_we && !w_busy && ({1'b0, i_cfg_id} < NP_W);

    //------------------------------------------------------------------
    // FSM: state register
    //------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------
    // FSM: next state
    //------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = S_CHK_ID;
            S_CHK_ID:  w_state_nxt = w_id_bad ? S_FAIL : S_CHK_AMT;
            S_CHK_AMT: w_state_nxt = (w_funds_bad || w_ovf_bad) ? S_FAIL : S_CHK_KEY;
            S_CHK_KEY: w_state_nxt = w_key_bad ? S_FAIL : S_COMMIT;
            S_COMMIT:  w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            S_FAIL:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    //------------------------------------------------------------------
    // FSM: outputs / datapath controls
    //------------------------------------------------------------------
    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_accept    = (r_state == S_IDLE) && i_start;
        w_commit    = (r_state == S_COMMIT);
        w_finish    = (r_state == S_DONE) || (r_state == S_FAIL);
        w_fail_set  = 1'b0;
        w_fail_code = ERR_OK;
        case (r_state)
            S_CHK_ID: begin
                if (w_id_bad) begin
                    w_fail_set  = 1'b1;
                    w_fail_code = ERR_ID;
                end
            end
            S_CHK_AMT: begin
                // Insufficient funds takes priority over payee overflow.
                if (w_funds_bad) begin
                    w_fail_set  = 1'b1;
                    w_fail_code = ERR_FUNDS;
                end else if (w_ovf_bad) begin
                    w_fail_set  = 1'b1;
                    w_fail_code = ERR_OVF;
                end
            end
            S_CHK_KEY: begin
                if (w_key_bad) begin
                    w_fail_set  = 1'b1;
                    w_fail_code = ERR_KEY;
                end
            end
            default: begin
                w_fail_set  = 1'b0;
                w_fail_code = ERR_OK;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Request latch and result registers
    //------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_amt       <= '0;
            r_key       <= '0;
            r_fail_code <= ERR_OK;
            r_done      <= 1'b0;
            r_err       <= ERR_OK;
        end else begin
            if (w_accept) begin
                r_src <= i_src_id;
                r_dst <= i_dst_id;
                r_amt <= i_input_amount;
                r_key <= i_input_key;
            end
            if (w_fail_set) begin
                r_fail_code <= w_fail_code;
            end
            // done is registered from DONE/FAIL, so the pulse lands while the
            // FSM is already back in IDLE and a new start can be taken.
            r_done <= w_finish;
            if (w_finish) begin
                r_err <= (r_state == S_FAIL) ? r_fail_code : ERR_OK;
            end
        end
    end

    //------------------------------------------------------------------
    // Account storage. cfg writes only happen in IDLE and commits only in
    // COMMIT, so the two write sources never collide.
    //------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bal[i] <= '0;
                r_pub[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_bal[i_cfg_id] <= i_cfg_balance;
            r_pub[i_cfg_id] <= i_cfg_pubkey;
        end else if (w_commit) begin
            r_bal[r_src] <= w_src_bal - r_amt;
            r_bal[r_dst] <= w_sum[AMT_W-1:0];
        end
    end

`ifdef TX_COUNT_EN
    logic [15:0] r_tx_count;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_tx_count <= 16'h0000;
        end else if (w_commit) begin
            r_tx_count <= r_tx_count + 16'h0001;
        end
    end

    assign o_tx_count = r_tx_count;
`else
    assign o_tx_count = 16'h0000;
`endif

    assign o_rd_balance = ({1'b0, i_rd_id} < NP_W) ? r_bal[i_rd_id] : '0;
    assign o_busy       = w_busy;
    assign o_done       = r_done;
    assign o_err_code   = r_err;

endmodule

// File: tb/tb_transfer_engine.sv
// Directed bench for transfer_engine: hand-computed balances, latencies and error codes.
// Key material: private key 8'h3C -> rotl3 = 8'hE1 -> ^8'hA5 = 8'h44 (public key).
// A wrong private key 8'h3D maps to 8'h4C.

module tb_transfer_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  src_id, dst_id, cfg_id, rd_id;
    logic [10:0] amt, cfg_bal, rd_bal;
    logic [7:0]  key, cfg_key;
    logic        cfg_we;
    logic        busy, done;
    logic [2:0]  err;
    logic [15:0] txc;

    int n_chk  = 0;
    int n_pass = 0;
    int n_commit = 0;

    localparam logic [7:0] GOOD_KEY = 8'h3C;
    localparam logic [7:0] BAD_KEY  = 8'h3D;
    localparam logic [7:0] PUB_KEY  = 8'h44;

    always #5 clk = ~clk;

    transfer_engine dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_start        (start),
        .i_src_id       (src_id),
        .i_dst_id       (dst_id),
        .i_input_amount (amt),
        .i_input_key    (key),
        .i_cfg_we       (cfg_we),
        .i_cfg_id       (cfg_id),
        .i_cfg_balance  (cfg_bal),
        .i_cfg_pubkey   (cfg_key),
        .i_rd_id        (rd_id),
        .o_rd_balance   (rd_bal),
        .o_busy         (busy),
        .o_done         (done),
        .o_err_code     (err),
        .o_tx_count     (txc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_tx();
`ifdef TX_COUNT_EN
        return 32'(n_commit);
`else
        return 32'd0;
`endif
    endfunction

    task automatic bal_chk(input string tag, input logic [10:0] b0, input logic [10:0] b1,
                           input logic [10:0] b2, input logic [10:0] b3);
        logic [10:0] exp [4];
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3;
        for (int i = 0; i < 4; i++) begin
            rd_id = 2'(i);
            #1;
            check($sformatf("%s.bal%0d", tag, i), 32'(rd_bal), 32'(exp[i]));
        end
    endtask

    task automatic cfg_write(input logic [1:0] id, input logic [10:0] b, input logic [7:0] k);
        cfg_id = id; cfg_bal = b; cfg_key = k; cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // Drives a request from the current (off-edge) time; counts edges after the
    // accept edge until done is seen, bounded at 12.
    task automatic run_tx(input string tag, input logic [1:0] s, input logic [1:0] d,
                          input logic [10:0] a, input logic [7:0] k,
                          input logic [2:0] e, input int lat);
        int got;
        got = 0;
        src_id = s; dst_id = d; amt = a; key = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cfg_we = 1'b0;
        check({tag, ".busy"}, 32'(busy), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done) begin
                got = c;
                break;
            end
        end
        check({tag, ".lat"}, 32'(got), 32'(lat));
        check({tag, ".err"}, 32'(err), 32'(e));
        if (e == 3'd0 && got != 0) n_commit++;
    endtask

    initial begin
        int got;
        int dones;
        rst = 1'b1; start = 1'b0; cfg_we = 1'b0;
        src_id = '0; dst_id = '0; amt = '0; key = '0;
        cfg_id = '0; cfg_bal = '0; cfg_key = '0; rd_id = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.err",  32'(err),  32'd0);
        check("rst.tx",   32'(txc),  32'd0);
        bal_chk("rst", 11'd0, 11'd0, 11'd0, 11'd0);

        cfg_write(2'd0, 11'd100,  PUB_KEY);
        cfg_write(2'd1, 11'd50,   PUB_KEY);
        cfg_write(2'd2, 11'd0,    PUB_KEY);
        cfg_write(2'd3, 11'd2040, PUB_KEY);
        bal_chk("cfg", 11'd100, 11'd50, 11'd0, 11'd2040);

        // Plain success: 100/50 -> 70/80
        run_tx("ok30", 2'd0, 2'd1, 11'd30, GOOD_KEY, 3'd0, 5);
        bal_chk("ok30", 11'd70, 11'd80, 11'd0, 11'd2040);
        check("ok30.tx", 32'(txc), exp_tx());

        // Funds: 71 > 70
        run_tx("funds", 2'd0, 2'd1, 11'd71, GOOD_KEY, 3'd1, 3);
        // Key
        run_tx("key", 2'd0, 2'd1, 11'd10, BAD_KEY, 3'd2, 4);
        // Id: src == dst
        run_tx("id", 2'd2, 2'd2, 11'd1, GOOD_KEY, 3'd3, 2);
        // Payee overflow: 2040 + 10 > 2047
        run_tx("ovf", 2'd0, 2'd3, 11'd10, GOOD_KEY, 3'd4, 3);
        bal_chk("fails", 11'd70, 11'd80, 11'd0, 11'd2040);

        // Zero amount commits with no change; next request started in the done cycle
        run_tx("zero", 2'd0, 2'd1, 11'd0, GOOD_KEY, 3'd0, 5);
        check("b2b.done_cycle", 32'(done), 32'd1);
        run_tx("b2b", 2'd0, 2'd1, 11'd5, GOOD_KEY, 3'd0, 5);
        bal_chk("b2b", 11'd65, 11'd85, 11'd0, 11'd2040);
        check("b2b.tx", 32'(txc), exp_tx());

        // start while busy is dropped, latched amount unchanged
        src_id = 2'd1; dst_id = 2'd0; amt = 11'd10; key = GOOD_KEY; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        amt = 11'd40; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 0;
        for (int c = 3; c <= 12; c++) begin
            @(posedge clk); #1;
            if (done) begin
                got = c;
                break;
            end
        end
        check("busy_ign.lat", 32'(got), 32'd5);
        check("busy_ign.err", 32'(err), 32'd0);
        n_commit++;
        dones = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("busy_ign.extra_done", 32'(dones), 32'd0);
        bal_chk("busy_ign", 11'd75, 11'd75, 11'd0, 11'd2040);

        // cfg write in the same IDLE cycle as start: the check sees the new 500
        cfg_id = 2'd2; cfg_bal = 11'd500; cfg_key = PUB_KEY; cfg_we = 1'b1;
        run_tx("cfg_start", 2'd2, 2'd1, 11'd300, GOOD_KEY, 3'd0, 5);
        bal_chk("cfg_start", 11'd75, 11'd375, 11'd200, 11'd2040);
        check("cfg_start.tx", 32'(txc), exp_tx());

`ifdef TX_COUNT_EN
        force dut.r_tx_count = 16'hFFFF;
        #1 release dut.r_tx_count;
        run_tx("wrap", 2'd0, 2'd1, 11'd0, GOOD_KEY, 3'd0, 5);
        check("wrap.tx", 32'(txc), 32'd0);
`endif

        // Leave a non-zero err before the reset abort
        run_tx("id2", 2'd1, 2'd1, 11'd1, GOOD_KEY, 3'd3, 2);

        // Reset while in CHK_KEY: no done, everything cleared
        src_id = 2'd0; dst_id = 2'd1; amt = 11'd5; key = GOOD_KEY; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dones = 0;
        if (done) dones++;
        repeat (8) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("abort.done", 32'(dones), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.err",  32'(err),  32'd0);
        check("abort.tx",   32'(txc),  32'd0);
        bal_chk("abort", 11'd0, 11'd0, 11'd0, 11'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
